wb_sad_select: RTL

- Write-back stage consumer sitting directly after the MEM/WB pipeline register; drives the register-file write port.
- Normal path: selects and load-extends the write-back data combinationally from MEM/WB outputs.
- Competition path: sequential min/max finder over the 8 latched SAD results, plus a deferred write of the winning value or index into Rd when the scan is still running.

---
 rtl/wb_sad_select.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/wb_sad_select.sv
// Write-back stage: drives the register-file write port from the MEM/WB outputs.
// Also runs a min/max search over the 8 SAD results and can write the winner into Rd.
//
// state | meaning
// IDLE  | no result yet, waiting for a scan start
// SCAN  | comparing entries 1..NUM_SAD-1 against the running best
// WRITE | scan finished with a deferred write outstanding
// DONE  | winner valid; requests are served in the same cycle
module wb_sad_select #(
  parameter int NUM_SAD = 8,
  parameter int DATA_W  = 32,
  parameter int IDX_W   = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                LoadMux_in,
  input  logic [1:0]                MemToReg_in,
  input  logic                      RegWrite_in,
  input  logic [DATA_W-1:0]         ALUResult_in,
  input  logic [DATA_W-1:0]         MemContent_in,
  input  logic [DATA_W-1:0]         PCplus4_in,
  input  logic [DATA_W-1:0]         Rs_in,
  input  logic [4:0]                RdAddress_in,
  input  logic                      small_big_find_in,
  input  logic                      small_big_regFile_in,
  input  logic                      read_min_in,
  input  logic                      write_min_in,
  input  logic [NUM_SAD*DATA_W-1:0] sad_results_in,
  output logic                      reg_write_en_out,
  output logic [4:0]                reg_write_addr_out,
  output logic [DATA_W-1:0]         reg_write_data_out,
  output logic                      sad_busy_out,
  output logic                      sad_valid_out,
  output logic [DATA_W-1:0]         sad_win_value_out,
  output logic [IDX_W-1:0]          sad_win_index_out
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WRITE, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [DATA_W-1:0] r_buf [NUM_SAD];
  logic              r_mode;
  logic [DATA_W-1:0] r_best;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  r_cnt;
  logic              r_valid;
  logic              r_pend;
  logic              r_pend_val;
  logic [4:0]        r_pend_rd;

  logic              w_start;
  logic              w_last;
  logic              w_req;
  logic              w_capture;
  logic              w_better;
  logic              w_imm;
  logic              w_pend_fire;
  logic [DATA_W-1:0] w_cand;
  logic [DATA_W-1:0] w_ext;
  logic [DATA_W-1:0] w_norm_data;
  logic [DATA_W-1:0] w_idx_ext;
  logic              w_en;
  logic [4:0]        w_addr;
  logic [DATA_W-1:0] w_data;

  assign w_start     = ((r_state == S_IDLE) || (r_state == S_DONE)) && small_big_find_in;
  assign w_last      = (r_cnt == IDX_W'(NUM_SAD - 1));
  assign w_req       = read_min_in | write_min_in;
  assign w_capture   = (r_state == S_SCAN) && w_req && !r_pend;
  assign w_cand      = r_buf[r_cnt];
  assign w_better    = r_mode ? (w_cand > r_best) : (w_cand < r_best);
  assign w_pend_fire = (r_state == S_WRITE) && !RegWrite_in;
  // Immediate service only once the winner is settled and no deferred write is queued.
  assign w_imm       = (r_state == S_DONE) && r_valid && w_req;
  assign w_idx_ext   = {{(DATA_W-IDX_W){1'b0}}, r_idx};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (small_big_find_in) w_state_nxt = S_SCAN;
      S_SCAN:         if (w_last) w_state_nxt = (r_pend || w_capture) ? S_WRITE : S_DONE;
      S_WRITE:        if (!RegWrite_in) w_state_nxt = S_DONE;
      default:        w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_SAD; i++) r_buf[i] <= '0;
      r_mode  <= 1'b0;
      r_best  <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else if (w_start) begin
      for (int i = 0; i < NUM_SAD; i++) r_buf[i] <= sad_results_in[i*DATA_W +: DATA_W];
      r_mode  <= small_big_regFile_in;
      r_best  <= sad_results_in[DATA_W-1:0];
      r_idx   <= '0;
      r_cnt   <= IDX_W'(1);
      r_valid <= 1'b0;
    end else if (r_state == S_SCAN) begin
      // Strict compare keeps the lowest index on ties.
      if (w_better) begin
        r_best <= w_cand;
        r_idx  <= r_cnt;
      end
      r_cnt <= r_cnt + IDX_W'(1);
      if (w_last) r_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend     <= 1'b0;
      r_pend_val <= 1'b0;
      r_pend_rd  <= '0;
    end else if (w_capture) begin
      r_pend     <= 1'b1;
      r_pend_val <= read_min_in;
      r_pend_rd  <= RdAddress_in;
    end else if (w_pend_fire) begin
      r_pend <= 1'b0;
    end
  end

  always_comb begin
    w_ext = MemContent_in;
    case (LoadMux_in)
      2'd1:    w_ext = {{(DATA_W-8){MemContent_in[7]}}, MemContent_in[7:0]};
      2'd2:    w_ext = {{(DATA_W-8){1'b0}}, MemContent_in[7:0]};
      2'd3:    w_ext = {{(DATA_W-16){MemContent_in[15]}}, MemContent_in[15:0]};
      default: w_ext = MemContent_in;
    endcase
    w_norm_data = ALUResult_in;
    case (MemToReg_in)
      2'd1:    w_norm_data = w_ext;
      2'd2:    w_norm_data = PCplus4_in;
      2'd3:    w_norm_data = Rs_in;
      default: w_norm_data = ALUResult_in;
    endcase
  end

  always_comb begin
    w_en   = RegWrite_in;
    w_addr = RdAddress_in;
    w_data = w_norm_data;
    if (w_pend_fire) begin
      w_en   = 1'b1;
      w_addr = r_pend_rd;
      w_data = r_pend_val ? r_best : w_idx_ext;
    end else if (w_imm) begin
      w_en   = 1'b1;
      w_data = read_min_in ? r_best : w_idx_ext;
    end
    if (w_addr == 5'd0) w_en = 1'b0;
    if (!rst) begin
      w_en   = 1'b0;
      w_addr = '0;
      w_data = '0;
    end
  end

  assign reg_write_en_out   = w_en;
  assign reg_write_addr_out = w_addr;
  assign reg_write_data_out = w_data;
  assign sad_busy_out       = (r_state == S_SCAN);
  assign sad_valid_out      = r_valid;
  assign sad_win_value_out  = r_best;
  assign sad_win_index_out  = r_idx;

endmodule
